// File: rtl/mult_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Number of compute cycles needed to consume all multiplier bits.
    function automatic int calc_steps(input int width, input int step);
        return width / step;
    endfunction

    function automatic int cnt_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit step_ok(input int width, input int step);
        return (step >= 1) && (step <= width) && ((width % step) == 0);
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: adds m times a STEP-bit multiplier slice into the accumulator.
module mult_step #(
    parameter int WIDTH = 6,
    parameter int STEP  = 1
) (
    input  logic [2*WIDTH-1:0] m,
    input  logic [STEP-1:0]    slice,
    input  logic [2*WIDTH-1:0] acc_in,
    output logic [2*WIDTH-1:0] acc_out
);
    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] partial;

    always_comb begin
        partial = m * PW'(slice);
        acc_out = acc_in + partial;
    end

endmodule

// File: rtl/iter_multiplier.sv
// Iterative signed/unsigned multiplier retiring STEP multiplier bits per clock,
// with a start/busy/done handshake and a product held until the next result.
module iter_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW    = 2 * WIDTH;
    localparam int N     = calc_steps(WIDTH, STEP);
    localparam int CNT_W = cnt_bits(N);

    generate
        if (!step_ok(WIDTH, STEP)) begin : g_bad_step
            $error("iter_multiplier: STEP must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d;
    logic [PW-1:0]      m_q, m_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      product_q, product_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [PW-1:0]      acc_step;
    logic               last_step;
    logic               load;

    mult_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .m       (m_q),
        .slice   (p_q[STEP-1:0]),
        .acc_in  (acc_q),
        .acc_out (acc_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            p_q       <= '0;
            m_q       <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // A start seen on the final compute edge is accepted so that a held start
    // gives one operation every N cycles.
    always_comb begin
        last_step = (state_q == CALC) && (cnt_q == CNT_W'(N - 1));
        load      = start && ((state_q == IDLE) || last_step);
        state_d   = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_step) state_d = start ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        a_mag     = (signed_mode && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
        b_mag     = (signed_mode && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
        p_d       = p_q;
        m_d       = m_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        if (state_q == CALC) begin
            acc_d = acc_step;
            m_d   = m_q << STEP;
            p_d   = p_q >> STEP;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
                product_d = neg_q ? -acc_step : acc_step;
                done_d    = 1'b1;
            end
        end
        if (load) begin
            p_d   = a_mag;
            m_d   = PW'(b_mag);
            acc_d = '0;
            neg_d = signed_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
            cnt_d = '0;
        end
    end

    always_comb begin
        busy    = (state_q == CALC);
        done    = done_q;
        product = product_q;
    end

endmodule

// File: tb/tb_iter_multiplier.sv
// Scoreboard bench driving three multiplier configurations (6/1, 6/2, 8/4)
// against an integer-arithmetic reference.
module tb_iter_multiplier;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          passed = 0;
    bit          mon_en = 1'b0;

    logic [2:0]  start_all = '0;
    logic [2:0]  sm_all = '0;
    logic [7:0]  a_all [3];
    logic [7:0]  b_all [3];
    logic [2:0]  busy_all;
    logic [2:0]  done_all;
    logic [15:0] prod_all [3];
    logic [15:0] last_prod [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    logic [11:0] prod0, prod1;
    logic [15:0] prod2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    iter_multiplier #(.WIDTH(6), .STEP(1)) dut0 (
        .clk(clk), .rst(rst), .start(start_all[0]), .signed_mode(sm_all[0]),
        .multiplier(a_all[0][5:0]), .multiplicand(b_all[0][5:0]),
        .busy(busy_all[0]), .done(done_all[0]), .product(prod0));

    iter_multiplier #(.WIDTH(6), .STEP(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_all[1]), .signed_mode(sm_all[1]),
        .multiplier(a_all[1][5:0]), .multiplicand(b_all[1][5:0]),
        .busy(busy_all[1]), .done(done_all[1]), .product(prod1));

    iter_multiplier #(.WIDTH(8), .STEP(4)) dut2 (
        .clk(clk), .rst(rst), .start(start_all[2]), .signed_mode(sm_all[2]),
        .multiplier(a_all[2]), .multiplicand(b_all[2]),
        .busy(busy_all[2]), .done(done_all[2]), .product(prod2));

    assign prod_all[0] = {4'b0, prod0};
    assign prod_all[1] = {4'b0, prod1};
    assign prod_all[2] = prod2;

    function automatic int wid(input int d);
        return (d == 2) ? 8 : 6;
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 6 : ((d == 1) ? 3 : 2);
    endfunction

    // Reference: interpret operands as integers and multiply, then wrap to 2*w bits.
    function automatic logic [15:0] ref_mult(input int w, input bit sm,
                                             input logic [7:0] a, input logic [7:0] b);
        longint sa, sb, pr, mask;
        mask = (longint'(1) << w) - 1;
        sa = longint'(a) & mask;
        sb = longint'(b) & mask;
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        pr = sa * sb;
        pr = pr & ((longint'(1) << (2 * w)) - 1);
        return 16'(pr);
    endfunction

    function automatic logic [7:0] pick(input int w);
        logic [7:0] mask;
        mask = 8'((16'd1 << w) - 1);
        case ($urandom_range(0, 4))
            0:       return 8'd0;
            1:       return mask;
            2:       return 8'(16'd1 << (w - 1));
            default: return 8'($urandom) & mask;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input int d, input bit sm, input logic [7:0] a,
                        input logic [7:0] b, input int acc_cyc);
        exp_t e;
        e.prod = ref_mult(wid(d), sm, a, b);
        e.cyc  = acc_cyc + lat(d);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (busy_all[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy_all[d]) check("idle_timeout", 16'(busy_all[d]), 16'd0);
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic issue(input int d, input bit sm, input logic [7:0] a, input logic [7:0] b);
        wait_idle(d);
        start_all[d] = 1'b1;
        sm_all[d]    = sm;
        a_all[d]     = a;
        b_all[d]     = b;
        @(posedge clk);
        #1;
        push(d, sm, a, b, cyc);
        @(negedge clk);
        start_all[d] = 1'b0;
    endtask

    task automatic monitor_dut(input int d, input bit has, input exp_t e);
        if (done_all[d]) begin
            if (!has) begin
                check($sformatf("unexpected_done%0d", d), 16'(done_all[d]), 16'd0);
            end else begin
                check($sformatf("product%0d", d), prod_all[d], e.prod);
                check($sformatf("latency%0d", d), 16'(cyc), 16'(e.cyc));
                last_prod[d] = e.prod;
            end
        end else begin
            check($sformatf("hold%0d", d), prod_all[d], last_prod[d]);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        bit   has;
        if (mon_en) begin
            e = '{prod: 16'd0, cyc: 0};
            has = (q0.size() > 0) && done_all[0];
            if (has) e = q0.pop_front();
            monitor_dut(0, has, e);
            has = (q1.size() > 0) && done_all[1];
            if (has) e = q1.pop_front();
            monitor_dut(1, has, e);
            has = (q2.size() > 0) && done_all[2];
            if (has) e = q2.pop_front();
            monitor_dut(2, has, e);
        end
    end

    initial begin
        logic [7:0] a, b;
        bit         sm;
        int         n;
        for (int d = 0; d < 3; d++) begin
            a_all[d] = '0;
            b_all[d] = '0;
            last_prod[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check("reset_busy", 16'(busy_all[d]), 16'd0);
            check("reset_done", 16'(done_all[d]), 16'd0);
            check("reset_product", prod_all[d], 16'd0);
        end
        mon_en = 1'b1;

        // 63*63 unsigned with busy profile across the six compute cycles.
        issue(0, 1'b0, 8'd63, 8'd63);
        for (int i = 0; i < 6; i++) begin
            check("busy_during_calc", 16'(busy_all[0]), 16'd1);
            @(negedge clk);
        end
        check("busy_after_done", 16'(busy_all[0]), 16'd0);

        issue(0, 1'b1, 8'h20, 8'h20);
        issue(0, 1'b1, 8'h3F, 8'd5);
        issue(0, 1'b1, 8'd31, 8'h20);

        // Start re-asserted mid-operation must be ignored.
        issue(0, 1'b0, 8'd7, 8'd9);
        @(negedge clk);
        start_all[0] = 1'b1;
        a_all[0] = 8'd11;
        b_all[0] = 8'd13;
        @(negedge clk);
        a_all[0] = 8'd2;
        @(negedge clk);
        start_all[0] = 1'b0;
        wait_idle(0);

        // Reset in the middle of 20*20 aborts without a done pulse.
        issue(0, 1'b0, 8'd20, 8'd20);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        for (int d = 0; d < 3; d++) last_prod[d] = '0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 16'(busy_all[0]), 16'd0);
        check("abort_product", prod_all[0], 16'd0);
        issue(0, 1'b0, 8'd3, 8'd4);

        // Held start on the STEP=2 instance: one operation every three cycles.
        wait_idle(1);
        start_all[1] = 1'b1;
        sm_all[1] = 1'b0;
        a_all[1] = 8'd45;
        b_all[1] = 8'd27;
        @(posedge clk);
        #1;
        push(1, 1'b0, 8'd45, 8'd27, cyc);
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            sm = 1'($urandom);
            a = pick(6);
            b = pick(6);
            sm_all[1] = sm;
            a_all[1] = a;
            b_all[1] = b;
            repeat (3) @(posedge clk);
            #1;
            push(1, sm, a, b, cyc);
        end
        @(negedge clk);
        start_all[1] = 1'b0;

        issue(2, 1'b1, 8'h80, 8'd127);
        issue(2, 1'b1, 8'd0, 8'h9C);
        issue(2, 1'b0, 8'hFF, 8'hFF);

        // Randomized operations with idle gaps on every configuration.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 15; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk);
                issue(d, 1'($urandom), pick(wid(d)), pick(wid(d)));
            end
        end

        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 16'(q0.size() + q1.size() + q2.size()), 16'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
